// File: rtl/demux_1_to_n.sv
// demux_1_to_n: registered 1-to-N stream demultiplexer with valid/ready handshake.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; a beat is taken when both are high
//   in_sel [M]           destination channel index; values >= N are dropped
//   in_data [W]          payload
//   out_valid [N]        one-hot, bit i = beat pending for channel i
//   out_ready [N]        per-channel consumer ready
//   out_data [W]         payload, broadcast to all channels
//   err_clr              synchronous clear of err and drop_cnt
//   err                  sticky flag, an out-of-range beat was accepted
//   drop_cnt [C]         saturating count of dropped beats
module demux_1_to_n #(
  parameter int N = 9,
  parameter int M = 4,
  parameter int W = 8,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_sel,
  input  logic [W-1:0] in_data,
  output logic [N-1:0] out_valid,
  input  logic [N-1:0] out_ready,
  output logic [W-1:0] out_data,
  input  logic         err_clr,
  output logic         err,
  output logic [C-1:0] drop_cnt
);
  logic         r_hold_valid;
  logic [M-1:0] r_hold_sel;
  logic [W-1:0] r_hold_data;
  logic         r_err;
  logic [C-1:0] r_drop_cnt;
  logic         w_drain;
  logic         w_legal;
  logic         w_accept;
  logic         w_load;
  logic         w_drop;
  logic [C-1:0] w_drop_cnt_nxt;
  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_valid[i] = r_hold_valid && (r_hold_sel == M'(i));
  end
  // out_valid is one-hot, so masking it with out_ready picks the pending channel's
  // ready without indexing by a possibly out-of-range select.
  assign w_drain  = |(out_valid & out_ready);
  assign in_ready = !r_hold_valid || w_drain;
  // Extra bit keeps the compare correct when N == 2**M.
  assign w_legal  = {1'b0, in_sel} < (M+1)'(N);
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && w_legal;
  assign w_drop   = w_accept && !w_legal;
  assign out_data = r_hold_data;
  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;
  // A drop coinciding with err_clr counts from zero, so the drop wins.
  always_comb
    w_drop_cnt_nxt = w_drop ? (err_clr ? C'(1) : (&r_drop_cnt ? r_drop_cnt : r_drop_cnt + C'(1)))
                            : (err_clr ? '0 : r_drop_cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_sel   <= '0;
      r_hold_data  <= '0;
      r_err        <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_hold_valid <= w_load || (r_hold_valid && !w_drain);
      if (w_load) begin
        r_hold_sel  <= in_sel;
        r_hold_data <= in_data;
      end
      r_err      <= w_drop || (r_err && !err_clr);
      r_drop_cnt <= w_drop_cnt_nxt;
    end
endmodule

// File: tb/tb_demux_1_to_n.sv
// tb_demux_1_to_n: directed self-checking bench for demux_1_to_n.
module tb_demux_1_to_n;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [3:0] in_sel = 0;
  logic [7:0] in_data = 0;
  logic [8:0] out_valid;
  logic [8:0] out_ready = '1;
  logic [7:0] out_data;
  logic       err_clr = 0;
  logic       err;
  logic [7:0] drop_cnt;
  int n_cmp = 0;
  int n_err = 0;
  demux_1_to_n #(.N(9), .M(4), .W(8), .C(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_clr(err_clr),
    .err(err), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask
  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    rst_n = 1;
    tick();
    drive(1, 4'd3, 8'hA5);
    tick();
    chk("single_valid", 32'(out_valid), 32'h008);
    chk("single_data", 32'(out_data), 32'hA5);
    drive(0, 4'd0, 8'h00);
    tick();
    chk("single_idle", 32'(out_valid), 0);
    for (int k = 0; k < 9; k++) begin
      drive(1, 4'(k), 8'(8'h10 + k));
      chk("stream_in_ready", 32'(in_ready), 1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'(1) << k);
      chk("stream_data", 32'(out_data), 32'h10 + 32'(k));
    end
    drive(0, 4'd0, 8'h00);
    tick();
    chk("stream_idle", 32'(out_valid), 0);
    drive(1, 4'd5, 8'h55);
    tick();
    chk("bp_first", 32'(out_valid), 32'h020);
    out_ready = 9'h1DF;
    drive(1, 4'd1, 8'h66);
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'h020);
      chk("bp_hold_data", 32'(out_data), 32'h55);
    end
    out_ready = '1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_next_valid", 32'(out_valid), 32'h002);
    chk("bp_next_data", 32'(out_data), 32'h66);
    drive(0, 4'd0, 8'h00);
    tick();
    chk("bp_idle", 32'(out_valid), 0);
    drive(1, 4'd12, 8'h77);
    chk("ill_in_ready", 32'(in_ready), 1);
    tick();
    chk("ill_valid", 32'(out_valid), 0);
    chk("ill_err", 32'(err), 1);
    chk("ill_cnt1", 32'(drop_cnt), 1);
    for (int k = 0; k < 299; k++) tick();
    chk("ill_sat_cnt", 32'(drop_cnt), 255);
    chk("ill_sat_err", 32'(err), 1);
    chk("ill_sat_valid", 32'(out_valid), 0);
    err_clr = 1;
    tick();
    chk("clr_drop_err", 32'(err), 1);
    chk("clr_drop_cnt", 32'(drop_cnt), 1);
    drive(0, 4'd0, 8'h00);
    tick();
    chk("clr_err", 32'(err), 0);
    chk("clr_cnt", 32'(drop_cnt), 0);
    err_clr = 0;
    out_ready = 9'h1FB;
    drive(1, 4'd2, 8'h22);
    tick();
    drive(0, 4'd0, 8'h00);
    chk("mid_pending", 32'(out_valid), 32'h004);
    chk("mid_in_ready", 32'(in_ready), 0);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1;
    out_ready = '1;
    drive(1, 4'd7, 8'h7E);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'h080);
    chk("post_rst_data", 32'(out_data), 32'h7E);
    drive(0, 4'd0, 8'h00);
    tick();
    chk("post_rst_idle", 32'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
